kernel_line_buffer: RTL and testbench

//  Converts a raster RGB565 pixel stream (one pixel/cycle, hcount/vcount tagged) into vertical

---
 rtl/kernel_line_buffer.sv | 172 +++++++++++++++++
 tb/tb_kernel_line_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_line_buffer.sv
// kernel_line_buffer
//   Turns a raster RGB565 pixel stream (one pixel per cycle, tagged with
//   hcount/vcount) into vertical KERNEL_SIZE-pixel columns, one column per
//   cycle, for the convolution stages. KERNEL_SIZE+1 line RAMs rotate: one
//   takes the incoming line while the other KERNEL_SIZE are read at the same
//   column. Two register stages: the RAM read, then age ordering (and
//   optional border clamp) into the output registers.
//
//   Optional feature: define KERNEL_BORDER_CLAMP_EN to replace rows that fall
//   outside the frame (previous frame at the top, next frame at the bottom)
//   with the centre row. Without it, rows pass through raw.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   pixel_in        RGB565 pixel
//   hcount_in       pixel column; values >= HRES are ignored
//   vcount_in       pixel row
//   data_valid_in   input qualifier
//   data_out        packed columns, slice [0] = oldest (top) row
//   hcount_out      column of data_out
//   vcount_out      centre row of data_out
//   data_valid_out  output qualifier, held low until KERNEL_SIZE lines seen
module kernel_line_buffer #(
  parameter int HRES        = 320,
  parameter int VRES        = 180,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [15:0]               pixel_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      data_valid_in,
  output logic [KERNEL_SIZE*16-1:0] data_out,
  output logic [10:0]               hcount_out,
  output logic [9:0]                vcount_out,
  output logic                      data_valid_out
);

  localparam int NUM_LINES = KERNEL_SIZE + 1;
  localparam int AW        = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int SW        = $clog2(NUM_LINES);
  localparam int PW        = $clog2(KERNEL_SIZE + 1);

  localparam logic [10:0]   H_RES      = 11'(HRES);
  localparam logic [10:0]   H_LAST     = 11'(HRES - 1);
  localparam logic [9:0]    V_OFF      = 10'((KERNEL_SIZE + 1) / 2);
  localparam logic [9:0]    V_WRAP     = 10'(VRES - (KERNEL_SIZE + 1) / 2);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_LINES - 1);
  localparam logic [PW-1:0] PRIME_FULL = PW'(KERNEL_SIZE);

  logic          accept;
  logic          line_end;
  logic [AW-1:0] addr;

  assign accept   = data_valid_in && (hcount_in < H_RES);
  assign line_end = accept && (hcount_in == H_LAST);
  assign addr     = hcount_in[AW-1:0];

  logic [SW-1:0] wr_sel;
  logic [PW-1:0] prime_cnt;

  // Line RAMs plus their read register. No reset here so the pair maps onto
  // block RAM; contents survive reset and are only trusted once re-primed.
  logic [15:0] line_ram [NUM_LINES][HRES];
  logic [15:0] rd_s1 [NUM_LINES];

  always_ff @(posedge clk_in) begin
    if (accept) begin
      line_ram[wr_sel][addr] <= pixel_in;
      for (int j = 0; j < NUM_LINES; j++) begin
        rd_s1[j] <= line_ram[j][addr];
      end
    end
  end

  // Output row sits (K+1)/2 lines behind the line being written, wrapping
  // back into the previous frame at the top.
  logic [9:0] v_shift;
  always_comb begin
    v_shift = '0;
    if (vcount_in >= V_OFF) v_shift = vcount_in - V_OFF;
    else                    v_shift = vcount_in + V_WRAP;
  end

  logic [SW-1:0] sel_s1;
  logic [10:0]   hcount_s1;
  logic [9:0]    vcount_s1;
  logic          acc_s1;
  logic          valid_s1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_sel    <= '0;
      prime_cnt <= '0;
      sel_s1    <= '0;
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      acc_s1    <= 1'b0;
      valid_s1  <= 1'b0;
    end else begin
      acc_s1   <= accept;
      valid_s1 <= accept && (prime_cnt == PRIME_FULL);
      if (accept) begin
        // Snapshot before the advance so the last pixel of a line still
        // orders its reads against the line it belongs to.
        sel_s1    <= wr_sel;
        hcount_s1 <= hcount_in;
        vcount_s1 <= v_shift;
      end
      if (line_end) begin
        wr_sel <= (wr_sel == SEL_LAST) ? '0 : wr_sel + 1'b1;
        if (prime_cnt != PRIME_FULL) prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  // Age ordering: the oldest line lives in the RAM just after the write RAM,
  // so row i comes from (sel + 1 + i) mod NUM_LINES.
  logic [15:0] row     [KERNEL_SIZE];
  logic [15:0] row_out [KERNEL_SIZE];

  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      logic [SW:0] sum;
      sum = {1'b0, sel_s1} + (SW+1)'(1 + i);
      if (sum >= (SW+1)'(NUM_LINES)) sum = sum - (SW+1)'(NUM_LINES);
      row[i] = rd_s1[sum[SW-1:0]];
    end
  end

`ifdef KERNEL_BORDER_CLAMP_EN
  localparam int HALF = (KERNEL_SIZE - 1) / 2;

  // Row i holds line vcount + i - HALF; anything outside [0, VRES-1] is from
  // an adjacent frame and is replaced by the centre row.
  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      logic [11:0] lidx;
      lidx = {2'b00, vcount_s1} + 12'(i);
      if ((lidx < 12'(HALF)) || (lidx > 12'(VRES - 1 + HALF))) row_out[i] = row[HALF];
      else                                                     row_out[i] = row[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      row_out[i] = row[i];
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out       <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= valid_s1;
      if (acc_s1) begin
        hcount_out <= hcount_s1;
        vcount_out <= vcount_s1;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
          data_out[i*16 +: 16] <= row_out[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_line_buffer.sv
module tb_kernel_line_buffer;

  localparam int HRES = 8;
  localparam int VRES = 6;
  localparam int K    = 3;

  logic           clk_in;
  logic           rst_n_in;
  logic [15:0]    pixel_in;
  logic [10:0]    hcount_in;
  logic [9:0]     vcount_in;
  logic           data_valid_in;
  logic [K*16-1:0] data_out;
  logic [10:0]    hcount_out;
  logic [9:0]     vcount_out;
  logic           data_valid_out;

  kernel_line_buffer #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .pixel_in      (pixel_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .data_valid_in (data_valid_in),
    .data_out      (data_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .data_valid_out(data_valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: the last K completed lines, oldest first.
  typedef logic [15:0] line_t [HRES];
  line_t hist[$];
  line_t cur_line;

  // Expectation for the input driven one step earlier.
  logic            ep_valid;
  logic [K*16-1:0] ep_data;
  logic [10:0]     ep_h;
  logic [9:0]      ep_v;

  function automatic logic [15:0] pix(input int v, input int h);
    return {v[4:0], h[5:0], 5'b0};
  endfunction

  function automatic void model_reset();
    hist.delete();
    ep_valid = 1'b0;
    ep_data  = '0;
    ep_h     = '0;
    ep_v     = '0;
  endfunction

  // Drive one input cycle, advance the model, and check the output produced
  // by the previous input cycle (two register stages of latency).
  task automatic step(input logic vld, input logic [10:0] h, input logic [9:0] v,
                      input logic [15:0] p);
    logic            ex_valid;
    logic [K*16-1:0] ex_data;
    logic [9:0]      ex_v;
    int              idx;
    data_valid_in = vld;
    hcount_in     = h;
    vcount_in     = v;
    pixel_in      = p;
    ex_valid = 1'b0;
    ex_data  = '0;
    ex_v     = 10'((int'(v) + VRES - (K + 1) / 2) % VRES);
    if (vld && h < HRES) begin
      if (hist.size() == K) begin
        ex_valid = 1'b1;
        for (int i = 0; i < K; i++) ex_data[i*16 +: 16] = hist[i][h];
`ifdef KERNEL_BORDER_CLAMP_EN
        for (int i = 0; i < K; i++) begin
          idx = int'(ex_v) + i - (K - 1) / 2;
          if (idx < 0 || idx > VRES - 1) ex_data[i*16 +: 16] = hist[(K - 1) / 2][h];
        end
`endif
      end
      cur_line[h] = p;
      if (h == HRES - 1) begin
        hist.push_back(cur_line);
        if (hist.size() > K) hist.delete(0);
      end
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (data_valid_out !== ep_valid) begin
      errors++;
      $display("FAIL valid t=%0t got %b exp %b", $time, data_valid_out, ep_valid);
    end
    if (ep_valid) begin
      checks++;
      if ({data_out, hcount_out, vcount_out} !== {ep_data, ep_h, ep_v}) begin
        errors++;
        $display("FAIL column t=%0t got data=%h h=%0d v=%0d exp data=%h h=%0d v=%0d",
                 $time, data_out, hcount_out, vcount_out, ep_data, ep_h, ep_v);
      end
    end
    ep_valid = ex_valid;
    ep_data  = ex_data;
    ep_h     = h;
    ep_v     = ex_v;
  endtask

  task automatic idle();
    step(1'b0, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, VRES - 1)),
         16'($urandom));
  endtask

  task automatic send_line(input int v, input bit rand_pix, input bit gaps);
    for (int h = 0; h < HRES; h++) begin
      if (gaps && h > 0 && $urandom_range(0, 2) == 0) begin
        for (int g = 0; g < 3; g++) idle();
      end
      step(1'b1, 11'(h), 10'(v), rand_pix ? 16'($urandom) : pix(v, h));
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      data_valid_in = 1'($urandom);
      hcount_in     = 11'($urandom_range(0, HRES - 1));
      vcount_in     = 10'($urandom_range(0, VRES - 1));
      pixel_in      = 16'($urandom);
      @(posedge clk_in);
      #1;
      checks++;
      if ({data_out, hcount_out, vcount_out, data_valid_out} !== '0) begin
        errors++;
        $display("FAIL reset_hold got data=%h h=%0d v=%0d valid=%b exp all zero",
                 data_out, hcount_out, vcount_out, data_valid_out);
      end
    end
    #2 rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic test_priming();
    for (int v = 0; v < 3; v++) send_line(v, 1'b0, 1'b0);
    for (int h = 0; h < HRES; h++) begin
      step(1'b1, 11'(h), 10'd3, pix(3, h));
      if (h == 5) begin
        checks++;
        if (data_valid_out !== 1'b1 || hcount_out !== 11'd4 || vcount_out !== 10'd1 ||
            data_out !== {pix(2, 4), pix(1, 4), pix(0, 4)}) begin
          errors++;
          $display("FAIL first_column got valid=%b h=%0d v=%0d data=%h exp 1 4 1 %h",
                   data_valid_out, hcount_out, vcount_out, data_out,
                   {pix(2, 4), pix(1, 4), pix(0, 4)});
        end
      end
    end
    send_line(4, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
  endtask

  task automatic test_frame_wrap();
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < HRES; h++) begin
        step(1'b1, 11'(h), 10'(v), pix(v, h));
        if (h == 3) begin
          checks++;
          if (v == 0) begin
            if (vcount_out !== 10'd4 || data_out[47:32] !== pix(5, 2)) begin
              errors++;
              $display("FAIL wrap_top got v=%0d row2=%h exp 4 %h", vcount_out,
                       data_out[47:32], pix(5, 2));
            end
          end else if (v == 1) begin
`ifdef KERNEL_BORDER_CLAMP_EN
            if (vcount_out !== 10'd5 || data_out[47:32] !== data_out[31:16]) begin
              errors++;
              $display("FAIL clamp_bottom got v=%0d row2=%h exp 5 %h", vcount_out,
                       data_out[47:32], data_out[31:16]);
            end
`else
            if (vcount_out !== 10'd5 || data_out[47:32] !== pix(0, 2)) begin
              errors++;
              $display("FAIL raw_bottom got v=%0d row2=%h exp 5 %h", vcount_out,
                       data_out[47:32], pix(0, 2));
            end
`endif
          end else begin
`ifdef KERNEL_BORDER_CLAMP_EN
            if (vcount_out !== 10'd0 || data_out[15:0] !== data_out[31:16]) begin
              errors++;
              $display("FAIL clamp_top got v=%0d row0=%h exp 0 %h", vcount_out,
                       data_out[15:0], data_out[31:16]);
            end
`else
            if (vcount_out !== 10'd0 || data_out[15:0] !== pix(5, 2)) begin
              errors++;
              $display("FAIL raw_top got v=%0d row0=%h exp 0 %h", vcount_out,
                       data_out[15:0], pix(5, 2));
            end
`endif
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    for (int v = 3; v < VRES; v++) send_line(v, 1'b1, 1'b1);
    for (int v = 0; v < VRES; v++) send_line(v, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midline();
    for (int h = 0; h <= 5; h++) step(1'b1, 11'(h), 10'd0, 16'($urandom));
    checks++;
    if (data_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_drop_valid got %b exp 1", data_valid_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({data_out, hcount_out, vcount_out, data_valid_out} !== '0) begin
      errors++;
      $display("FAIL async_drop got data=%h h=%0d v=%0d valid=%b exp all zero",
               data_out, hcount_out, vcount_out, data_valid_out);
    end
    for (int c = 0; c < 2; c++) begin
      data_valid_in = 1'b0;
      @(posedge clk_in);
    end
    #3 rst_n_in = 1'b1;
    model_reset();
    for (int v = 0; v < 4; v++) send_line(v, 1'b1, 1'b0);
    step(1'b1, 11'(HRES), 10'd4, 16'($urandom));
    step(1'b1, 11'(HRES + 3), 10'd4, 16'($urandom));
    send_line(4, 1'b1, 1'b1);
    step(1'b1, 11'(HRES), 10'd5, 16'($urandom));
    idle();
    idle();
  endtask

  initial begin
    rst_n_in      = 1'b0;
    pixel_in      = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    data_valid_in = 1'b0;
    model_reset();
    test_reset();
    test_priming();
    test_frame_wrap();
    test_gaps();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
